// File: rtl/blur_window_loader.sv
// blur_window_loader: fetches the 4x5 source window at the anchor.
// Reads bytes from the frame SRAM; presents 20 pixels with valid/ready.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   anchor_moving       start pulse, origin from anchor_x/anchor_y
//   mem_rd, mem_addr    byte read strobe and address
//   mem_rdata           read data, RD_LAT cycles after mem_rd
//   window_out[20]      window, index k = row k/5, column k%5
//   window_valid        window complete and stable
//   window_ready        consumer accepts the window
//   busy                high outside IDLE
//
// Build option WINDOW_EDGE_REPLICATE_EN: clamp out-of-frame
// coordinates and read edge pixels instead of padding with zero.
`timescale 1ns/1ps
module blur_window_loader #(
  parameter int unsigned       IMG_W     = 640,
  parameter int unsigned       IMG_H     = 480,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       RD_LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              anchor_moving,
  input  logic [31:0]       anchor_x,
  input  logic [31:0]       anchor_y,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        window_out [20],
  output logic              window_valid,
  input  logic              window_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    VALID
  } state_t;

  typedef struct packed {
    logic       v;
    logic       pad;
    logic [4:0] k;
  } tag_t;

  state_t state_q, state_d;

  logic [31:0]       ax_q, ay_q;
  logic [4:0]        k_q;
  logic [1:0]        r_q;
  logic [2:0]        c_q;
  logic              rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        win_q [20];

  // tag_q[0] travels with the issued strobe; tag_q[RD_LAT]
  // lines up with the cycle its data is on mem_rdata.
  tag_t tag_q [RD_LAT+1];

  logic              fetch;
  logic              last_wr;
  logic [32:0]       px, py, cx, cy;
  logic              inframe;
  logic              rd_d;
  logic              pad_d;
  logic [ADDR_W-1:0] addr_d;
  tag_t              tag_d;

  assign last_wr = tag_q[RD_LAT].v &&
                   (tag_q[RD_LAT].k == 5'd19);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (anchor_moving)   state_d = FETCH;
      FETCH: if (k_q == 5'd19)    state_d = DRAIN;
      DRAIN: if (last_wr)         state_d = VALID;
      VALID: if (window_ready)    state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Outputs and fetch address generation
  always_comb begin
    fetch        = (state_q == FETCH);
    window_valid = (state_q == VALID);
    busy         = (state_q != IDLE);
    // 33 bits so anchor + offset never wraps into the frame
    px      = {1'b0, ax_q} + 33'(c_q);
    py      = {1'b0, ay_q} + 33'(r_q);
    inframe = (px < 33'(IMG_W)) && (py < 33'(IMG_H));
`ifdef WINDOW_EDGE_REPLICATE_EN
    cx    = (px > 33'(IMG_W - 1)) ? 33'(IMG_W - 1) : px;
    cy    = (py > 33'(IMG_H - 1)) ? 33'(IMG_H - 1) : py;
    rd_d  = fetch;
    pad_d = 1'b0;
`else
    cx    = px;
    cy    = py;
    rd_d  = fetch && inframe;
    pad_d = !inframe;
`endif
    addr_d = '0;
    if (rd_d)
      addr_d = BASE_ADDR +
               ADDR_W'(cy) * ADDR_W'(IMG_W) +
               ADDR_W'(cx);
    tag_d.v   = fetch;
    tag_d.pad = pad_d;
    tag_d.k   = k_q;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      ax_q   <= '0;
      ay_q   <= '0;
      k_q    <= '0;
      r_q    <= '0;
      c_q    <= '0;
      rd_q   <= 1'b0;
      addr_q <= '0;
      for (int i = 0; i <= RD_LAT; i++)
        tag_q[i] <= '0;
      for (int i = 0; i < 20; i++)
        win_q[i] <= 8'h00;
    end else begin
      if (state_q == IDLE && anchor_moving) begin
        ax_q <= anchor_x;
        ay_q <= anchor_y;
        k_q  <= '0;
        r_q  <= '0;
        c_q  <= '0;
      end else if (fetch) begin
        k_q <= k_q + 5'd1;
        if (c_q == 3'd4) begin
          c_q <= '0;
          r_q <= r_q + 2'd1;
        end else begin
          c_q <= c_q + 3'd1;
        end
      end
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      tag_q[0] <= tag_d;
      for (int i = 1; i <= RD_LAT; i++)
        tag_q[i] <= tag_q[i-1];
      if (tag_q[RD_LAT].v)
        win_q[tag_q[RD_LAT].k] <=
          tag_q[RD_LAT].pad ? 8'h00 : mem_rdata;
    end
  end

  assign mem_rd     = rd_q;
  assign mem_addr   = addr_q;
  assign window_out = win_q;

endmodule

// File: tb/tb_blur_window_loader.sv
// tb_blur_window_loader: randomized scoreboard bench.
// SRAM model returns addr[7:0] RD_LAT cycles after each read.
`timescale 1ns/1ps
module tb_blur_window_loader;

  localparam int unsigned W    = 8;
  localparam int unsigned H    = 6;
  localparam int unsigned LAT  = 2;
  localparam logic [31:0] BASE = 32'h100;

  typedef logic [19:0][7:0] win_t;

  logic        clk = 0;
  logic        rst = 1;
  logic        anchor_moving = 0;
  logic [31:0] anchor_x = 0;
  logic [31:0] anchor_y = 0;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [7:0]  window_out [20];
  logic        window_valid;
  logic        window_ready = 0;
  logic        busy;

  int nchk = 0;
  int nerr = 0;
  int rd_cnt = 0;

  logic [31:0] addr_exp[$];
  win_t        win_exp[$];

  blur_window_loader #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(32),
    .BASE_ADDR(BASE), .RD_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .anchor_moving(anchor_moving),
    .anchor_x(anchor_x), .anchor_y(anchor_y),
    .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .window_out(window_out),
    .window_valid(window_valid),
    .window_ready(window_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // SRAM: byte at address a is a[7:0]; 8'hEE when nothing returns
  logic       sv [LAT];
  logic [7:0] sd [LAT];
  always @(posedge clk) begin
    sv[0] <= mem_rd;
    sd[0] <= mem_addr[7:0];
    for (int i = 1; i < LAT; i++) begin
      sv[i] <= sv[i-1];
      sd[i] <= sd[i-1];
    end
  end
  assign mem_rdata = sv[LAT-1] ? sd[LAT-1] : 8'hEE;

  function automatic win_t pack_win();
    win_t p;
    for (int k = 0; k < 20; k++) p[k] = window_out[k];
    return p;
  endfunction

  task automatic chk(input string nm,
                     input logic [159:0] act,
                     input logic [159:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    nchk++;
    nerr++;
    $display("FAIL %s act=event exp=none", nm);
  endtask

  // Reference: enumerate the window pixels, push their addresses
  task automatic model(input longint ax, input longint ay,
                       output win_t w, output int nrd,
                       output bit rd0);
    w = '0;
    nrd = 0;
    rd0 = 0;
    for (int k = 0; k < 20; k++) begin
      longint px, py;
      bit rd;
      logic [31:0] a;
      px = ax + k % 5;
      py = ay + k / 5;
      rd = (px < W) && (py < H);
`ifdef WINDOW_EDGE_REPLICATE_EN
      if (px > W - 1) px = W - 1;
      if (py > H - 1) py = H - 1;
      rd = 1;
`endif
      if (rd) begin
        a = 32'(longint'(BASE) + py * W + px);
        addr_exp.push_back(a);
        w[k] = a[7:0];
        nrd++;
      end
      if (k == 0) rd0 = rd;
    end
  endtask

  // Monitor: reads and accepted windows against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd) begin
        rd_cnt++;
        if (addr_exp.size() == 0) fail("spurious_rd");
        else chk("rd_addr", 160'(mem_addr),
                 160'(addr_exp.pop_front()));
      end
      if (window_valid && window_ready) begin
        if (win_exp.size() == 0) fail("spurious_win");
        else chk("window", pack_win(), win_exp.pop_front());
      end else if (window_valid && win_exp.size() == 0) begin
        fail("spurious_valid");
      end
    end
  end

  // Called at #1 after an edge with the DUT idle; returns
  // at #1 after the accept edge, DUT idle again.
  task automatic run_fetch(input logic [31:0] ax,
                           input logic [31:0] ay,
                           input int hold);
    win_t w;
    int   nrd, base, n;
    bit   rd0;
    model(ax, ay, w, nrd, rd0);
    win_exp.push_back(w);
    base          = rd_cnt;
    anchor_x      = ax;
    anchor_y      = ay;
    anchor_moving = 1;
    window_ready  = (hold == 0);
    @(posedge clk); #1;
    anchor_moving = 0;
    anchor_x      = $urandom;
    anchor_y      = $urandom;
    @(posedge clk); #1;
    chk("first_rd", 160'(mem_rd), 160'(rd0));
    chk("busy_fetch", 160'(busy), 160'(1));
    n = 1;
    while (!window_valid && n < 80) begin
      @(posedge clk); #1;
      n++;
    end
    if (!window_valid) begin
      fail("valid_timeout");
    end else begin
      chk("valid_edge", 160'(n), 160'(21 + LAT));
      for (int i = 0; i < hold; i++) begin
        chk("hold_valid", 160'(window_valid), 160'(1));
        chk("hold_win", pack_win(), w);
        anchor_moving = (i == 3);
        @(posedge clk); #1;
      end
      anchor_moving = 0;
      window_ready  = 1;
      @(posedge clk); #1;
    end
    window_ready = 0;
    chk("valid_drop", 160'(window_valid), 160'(0));
    chk("idle", 160'(busy), 160'(0));
    chk("idle_win", pack_win(), w);
    chk("rd_count", 160'(rd_cnt - base), 160'(nrd));
    chk("rd_left", 160'(addr_exp.size()), 160'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog act=running exp=done");
    $fatal(1);
  end

  initial begin
    win_t w;
    int   nrd;
    bit   rd0, vseen;

    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    chk("rst_rd", 160'(mem_rd), 160'(0));
    chk("rst_addr", 160'(mem_addr), 160'(0));
    chk("rst_valid", 160'(window_valid), 160'(0));
    chk("rst_busy", 160'(busy), 160'(0));
    chk("rst_win", pack_win(), 160'(0));
    @(posedge clk); #1;

    run_fetch(0, 0, 0);
    run_fetch(5, 3, 0);
    run_fetch(1, 2, 10);
    // accept, then start the next fetch in the idle cycle
    run_fetch(3, 0, 0);
    run_fetch(2, 1, 0);
    run_fetch(100, 100, 0);
    chk("far_win", pack_win(), 160'(0));

    // reset at edge 10 of a fetch
    model(0, 0, w, nrd, rd0);
    anchor_x = 0;
    anchor_y = 0;
    anchor_moving = 1;
    @(posedge clk); #1;
    anchor_moving = 0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    addr_exp.delete();
    chk("mid_rd", 160'(mem_rd), 160'(0));
    chk("mid_busy", 160'(busy), 160'(0));
    chk("mid_win", pack_win(), 160'(0));
    vseen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (window_valid) vseen = 1;
    end
    chk("mid_novalid", 160'(vseen), 160'(0));
    chk("mid_discard", pack_win(), 160'(0));

    for (int i = 0; i < 14; i++) begin
      logic [31:0] ax, ay;
      ax = $urandom_range(0, 9);
      ay = $urandom_range(0, 7);
      if (i % 4 == 3) ax = $urandom_range(8, 2000);
      if (i % 5 == 4) ay = $urandom_range(6, 2000);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      run_fetch(ax, ay, $urandom_range(0, 4));
    end

    repeat (5) @(posedge clk);
    chk("win_left", 160'(win_exp.size()), 160'(0));
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/blur_window_loader.md
Name: blur_window_loader

Overview:
- Producer side of the blur filter's pixel input. On an anchor move it fetches the 4-row x 5-column source window whose top-left pixel is the anchor.
- Reads are byte-wide and pipelined from the frame SRAM.
- Presents the 20 pixels as one parallel window, using a valid/ready handshake toward the blur controller.
- Out-of-frame pixels are padded and are never read from memory.

Parameters:
- IMG_W, 640, frame width in pixels.
- IMG_H, 480, frame height in pixels.
- ADDR_W, 32, SRAM byte-address width.
- BASE_ADDR, 0, address of pixel (0,0); row-major, one byte per pixel.
- RD_LAT, 2, SRAM read latency in cycles (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- anchor_moving  in  1  start pulse; window origin is taken from anchor_x/anchor_y.
- anchor_x  in  32  window left column.
- anchor_y  in  32  window top row.
- mem_rd  out  1  SRAM read strobe, one byte per cycle.
- mem_addr  out  ADDR_W  SRAM read address.
- mem_rdata  in  8  read data, valid RD_LAT cycles after its mem_rd.
- window_out  out  8 x [20]  unpacked pixel array; index k = row (k/5), column (k%5).
- window_valid  out  1  window complete and stable.
- window_ready  in  1  consumer accepts the window.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - state=IDLE; mem_rd=0, mem_addr=0, window_valid=0, busy=0.
  - All window_out entries = 0.
  - In-flight read tags are cleared.
- State IDLE:
  - anchor_moving=1 latches anchor_x/anchor_y, clears the fetch index k=0, and goes to FETCH.
- State FETCH, one k per cycle, k=0..19; r=k/5, c=k%5; px=ax+c, py=ay+r:
  - In-frame (px<IMG_W and py<IMG_H): mem_rd=1, mem_addr=BASE_ADDR+py*IMG_W+px, computed at ADDR_W bits with truncation.
  - Out-of-frame: mem_rd=0, and a pad tag for k enters the return pipeline.
  - The return pipeline is an RD_LAT-deep shift of {valid, pad, k}. On exit, window_out[k] takes mem_rdata, or the pad value for pad tags.
  - After k=19 go to DRAIN.
- State DRAIN:
  - Count RD_LAT cycles.
  - When the last tag has been written, go to VALID.
- State VALID:
  - window_valid=1; window_out is held stable.
  - window_ready=1 at the edge goes to IDLE, with window_valid low the next cycle.
  - A new anchor_moving in that same cycle is not accepted; it must come at or after the IDLE cycle.
- Latency:
  - anchor_moving sampled at edge 0; reads are issued at edges 1..20.
  - window_valid rises at edge 21+RD_LAT.
  - Minimum accepted period is 23+RD_LAT cycles.
- anchor_moving is ignored whenever busy=1. There is no queueing.
- Anchor values are held from the latch point; input changes mid-fetch have no effect.
- Coordinates use 32-bit unsigned compares, so anchor_x/anchor_y >= IMG_W/IMG_H make every pixel in that column/row out-of-frame.
- Reset mid-operation:
  - Everything returns to reset values at that edge.
  - Data returning after reset is discarded (tags cleared).
  - No window_valid is produced.
- window_out keeps its last values in IDLE; it is only overwritten by a new fetch.

Optional Feature:
- Macro WINDOW_EDGE_REPLICATE_EN.
- Defined:
  - Out-of-frame coordinates are clamped: px'=min(px,IMG_W-1), py'=min(py,IMG_H-1).
  - Every k issues a read (20 mem_rd pulses), so edge pixels are replicated.
- Undefined:
  - Out-of-frame pixels are padded with 8'h00 with no read.

Test Plan (bench: IMG_W=8, IMG_H=6, BASE_ADDR=0x100, RD_LAT=2, SRAM model data=addr[7:0]):
- Anchor (0,0) -> 20 mem_rd pulses on edges 1..20 with addresses 0x100..0x104, 0x108..0x10C, 0x110..0x114, 0x118..0x11C; window_valid at edge 23; window_out[0]=0x00, [5]=0x08, [19]=0x1C.
- Anchor (5,3), macro off -> exactly 9 mem_rd pulses (cols 5..7, rows 3..5); window_out[3],[4],[15..19]=0x00, [0]=0x1D. Macro on -> 20 pulses; [4]=0x1F, [19]=0x2F.
- Backpressure: window_ready low for 10 cycles after valid -> window_valid and window_out stable throughout; anchor_moving pulsed during that time is ignored (no mem_rd).
- rst=1 at edge 10 of a fetch -> next cycle mem_rd=0, busy=0, window_out all 0; no window_valid for 30 cycles.
- Back-to-back: window_ready=1 on the first valid cycle, anchor_moving on the following (IDLE) cycle -> second fetch starts immediately, with its first read one edge later.
- Anchor (100,100) -> zero mem_rd pulses; window_valid at edge 23 with all pixels 0x00 (macro off).
